// File: rtl/wdata_handler.sv
// Write data handler: waits for the read side to finish issuing operands, lets
// the skewed systolic array drain, then snapshots and saturates the accumulator
// matrix, clears the array and writes the result to memory port C one row per
// accepted cycle.
//
// Ports:
//   clk_i, rst_i       clock, asynchronous active-low reset
//   valid_i, addr_c_i  start request and result base byte address
//   ready_o            high only while idle
//   last_i             read data handler's final-operand pulse
//   c_i                N*N accumulator matrix, element (r,j) at (r*N+j)*ACC_WIDTH
//   clear_o            one-cycle accumulator clear
//   en_c_o, we_c_o     memory C enable / write enable
//   addr_c_o           memory C byte address
//   wdata_c_o          row data, element j at j*DATA_WIDTH
//   wready_i           memory accepts the current write
//   done_o             one-cycle pulse once all rows are written
module wdata_handler #(
    parameter int unsigned N          = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    input  logic [ADDR_WIDTH-1:0]         addr_c_i,
    output logic                          ready_o,
    input  logic                          last_i,
    input  logic [N*N*ACC_WIDTH-1:0]      c_i,
    output logic                          clear_o,
    output logic                          en_c_o,
    output logic                          we_c_o,
    output logic [ADDR_WIDTH-1:0]         addr_c_o,
    output logic [N*DATA_WIDTH-1:0]       wdata_c_o,
    input  logic                          wready_i,
    output logic                          done_o
);

    localparam int unsigned ROW_BITS  = N * DATA_WIDTH;
    localparam int unsigned ROW_BYTES = ROW_BITS / 8;
    localparam int unsigned MAT_BITS  = N * ROW_BITS;
    localparam int unsigned ROW_W     = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W     = $clog2(2 * N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_FLUSH,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ROW_W-1:0]        row_nxt_c;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [MAT_BITS-1:0]     buf_q, buf_d;
    logic [MAT_BITS-1:0]     sat_c;
    logic                    ready_q, ready_d;
    logic                    clear_q, clear_d;
    logic                    en_q, en_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ROW_BITS-1:0]     wdata_q, wdata_d;

    // Unsigned saturation of every accumulator down to the stored element width.
    always_comb begin
        sat_c = '0;
        for (int e = 0; e < int'(N * N); e++) begin
            if (c_i[e*ACC_WIDTH + DATA_WIDTH +: ACC_WIDTH - DATA_WIDTH] != '0) begin
                sat_c[e*DATA_WIDTH +: DATA_WIDTH] = '1;
            end else begin
                sat_c[e*DATA_WIDTH +: DATA_WIDTH] = c_i[e*ACC_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign row_nxt_c = row_q + ROW_W'(1);

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        base_d  = base_q;
        buf_d   = buf_q;
        addr_d  = '0;
        wdata_d = '0;

        case (state_q)
            S_IDLE: begin
                if (valid_i) begin
                    base_d  = addr_c_i;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (last_i) begin
                    cnt_d   = CNT_W'(2 * N - 2);
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                // Row 0 comes straight from the saturated snapshot since the
                // buffer is loaded on the same edge.
                buf_d   = sat_c;
                row_d   = '0;
                addr_d  = base_q;
                wdata_d = sat_c[0 +: ROW_BITS];
                state_d = S_WRITE;
            end
            S_WRITE: begin
                addr_d  = addr_q;
                wdata_d = wdata_q;
                if (wready_i) begin
                    if (row_q == ROW_W'(N - 1)) begin
                        addr_d  = '0;
                        wdata_d = '0;
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_nxt_c;
                        addr_d  = addr_q + ADDR_WIDTH'(ROW_BYTES);
                        wdata_d = buf_q[row_nxt_c*ROW_BITS +: ROW_BITS];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        clear_d = (state_d == S_CAPTURE);
        en_d    = (state_d == S_WRITE);
        done_d  = (state_d == S_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            buf_q   <= '0;
            ready_q <= 1'b1;
            clear_q <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            base_q  <= base_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
            clear_q <= clear_d;
            en_q    <= en_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ready_o   = ready_q;
    assign clear_o   = clear_q;
    assign en_c_o    = en_q;
    assign we_c_o    = en_q;
    assign addr_c_o  = addr_q;
    assign wdata_c_o = wdata_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_wdata_handler.sv
// Bench for wdata_handler: drives start/last/backpressure stimulus and checks
// every cycle against a timeline model built from the handler's published
// latencies and a saturating row model of the accumulator matrix.
module tb_wdata_handler;

    localparam int unsigned N          = 4;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ACC_WIDTH  = 20;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned ROW_BITS   = N * DATA_WIDTH;
    localparam int unsigned ROW_BYTES  = ROW_BITS / 8;

    logic                      clk_i;
    logic                      rst_i;
    logic                      valid_i;
    logic [ADDR_WIDTH-1:0]     addr_c_i;
    logic                      ready_o;
    logic                      last_i;
    logic [N*N*ACC_WIDTH-1:0]  c_i;
    logic                      clear_o;
    logic                      en_c_o;
    logic                      we_c_o;
    logic [ADDR_WIDTH-1:0]     addr_c_o;
    logic [ROW_BITS-1:0]       wdata_c_o;
    logic                      wready_i;
    logic                      done_o;

    int unsigned mat [N*N];
    int checks   = 0;
    int failures = 0;

    wdata_handler #(
        .N(N), .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .addr_c_i(addr_c_i),
        .ready_o(ready_o), .last_i(last_i), .c_i(c_i), .clear_o(clear_o),
        .en_c_o(en_c_o), .we_c_o(we_c_o), .addr_c_o(addr_c_o), .wdata_c_o(wdata_c_o),
        .wready_i(wready_i), .done_o(done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected memory row: each element saturates to all-ones at or above 2^DATA_WIDTH.
    function automatic logic [ROW_BITS-1:0] exp_row(input int r);
        logic [ROW_BITS-1:0] row;
        int unsigned v;
        row = '0;
        for (int j = 0; j < int'(N); j++) begin
            v = mat[r*N + j];
            if (v > 255) v = 255;
            row = row | (ROW_BITS'(v) << (j * DATA_WIDTH));
        end
        return row;
    endfunction

    task automatic load_matrix();
        for (int e = 0; e < int'(N * N); e++) begin
            c_i[e*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(mat[e]);
        end
    endtask

    // Advance to the start of the next cycle; inputs are driven here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_quiet(input string tag, input logic exp_ready);
        check({tag, "_ready"}, 64'(ready_o), 64'(exp_ready));
        check({tag, "_clear"}, 64'(clear_o), 64'd0);
        check({tag, "_en"},    64'(en_c_o),  64'd0);
        check({tag, "_done"},  64'(done_o),  64'd0);
        check({tag, "_addr"},  64'(addr_c_o), 64'd0);
    endtask

    // mode 0: wready always high, 1: random wready, 2: 3 stall cycles on row 1.
    // abort_row >= 0 drops reset while that row is presented.
    task automatic run_txn(input logic [31:0] base, input int mode, input bit inject,
                           input int abort_row);
        int r;
        int stalls;
        int guard;
        int armed_cycles;
        logic [31:0] exp_addr;
        load_matrix();

        if (inject) begin
            step();
            last_i = 1'b1;
            @(negedge clk_i);
            check_quiet("idle_pre", 1'b1);
            step();
            last_i = 1'b0;
            @(negedge clk_i);
            check_quiet("idle_last_ignored", 1'b1);
        end

        step();
        valid_i  = 1'b1;
        addr_c_i = base;
        @(negedge clk_i);
        check_quiet("start", 1'b1);
        step();
        valid_i  = inject;
        addr_c_i = $urandom;
        @(negedge clk_i);
        check_quiet("armed", 1'b0);

        armed_cycles = $urandom_range(0, 3);
        for (int k = 0; k < armed_cycles; k++) begin
            step();
            valid_i  = 1'(($urandom_range(0, 1)));
            addr_c_i = $urandom;
            @(negedge clk_i);
            check_quiet("armed_wait", 1'b0);
        end

        // Cycle t: last pulse.
        step();
        valid_i = 1'b0;
        last_i  = 1'b1;
        @(negedge clk_i);
        check_quiet("last_cycle", 1'b0);

        // Cycles t+1 .. t+2N-1: array drain.
        for (int k = 1; k < int'(2 * N); k++) begin
            step();
            last_i   = inject && (k == 2);
            valid_i  = inject && (k == 3);
            addr_c_i = $urandom;
            @(negedge clk_i);
            check_quiet("flush", 1'b0);
        end

        // Cycle t+2N: clear pulse.
        step();
        last_i  = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        check("clear_pulse", 64'(clear_o), 64'd1);
        check("clear_en", 64'(en_c_o), 64'd0);

        r = 0;
        stalls = 0;
        guard = 0;
        while (r < int'(N)) begin
            step();
            case (mode)
                0: wready_i = 1'b1;
                1: wready_i = ($urandom_range(0, 3) != 0);
                default: begin
                    wready_i = !(r == 1 && stalls < 3);
                    if (!wready_i) stalls++;
                end
            endcase
            @(negedge clk_i);
            exp_addr = base + 32'(r) * ROW_BYTES;
            check("wr_en", 64'(en_c_o), 64'd1);
            check("wr_we", 64'(we_c_o), 64'd1);
            check("wr_addr", 64'(addr_c_o), 64'(exp_addr));
            check("wr_data", 64'(wdata_c_o), 64'(exp_row(r)));
            check("wr_clear", 64'(clear_o), 64'd0);
            check("wr_done", 64'(done_o), 64'd0);
            if (r == abort_row) begin
                rst_i = 1'b0;
                #1;
                check_quiet("async_rst", 1'b1);
                check("async_rst_wdata", 64'(wdata_c_o), 64'd0);
                check("async_rst_we", 64'(we_c_o), 64'd0);
                step();
                wready_i = 1'b0;
                @(negedge clk_i);
                check_quiet("in_rst", 1'b1);
                rst_i = 1'b1;
                return;
            end
            if (wready_i) r++;
            guard++;
            if (guard > 64) begin
                check("write_timeout", 64'd1, 64'd0);
                return;
            end
        end

        step();
        wready_i = 1'b0;
        @(negedge clk_i);
        check("done_pulse", 64'(done_o), 64'd1);
        check("done_en", 64'(en_c_o), 64'd0);
        check("done_addr", 64'(addr_c_o), 64'd0);
        check("done_wdata", 64'(wdata_c_o), 64'd0);
        check("done_ready", 64'(ready_o), 64'd0);

        step();
        @(negedge clk_i);
        check_quiet("back_idle", 1'b1);
    endtask

    initial begin
        rst_i    = 1'b0;
        valid_i  = 1'b0;
        addr_c_i = '0;
        last_i   = 1'b0;
        c_i      = '0;
        wready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_quiet("reset", 1'b1);
        check("reset_wdata", 64'(wdata_c_o), 64'd0);
        rst_i = 1'b1;

        // Basic: element (r,j) = r*4+j.
        for (int e = 0; e < int'(N * N); e++) mat[e] = e;
        run_txn(32'h100, 0, 1'b0, -1);

        // Saturation on row 0, random backpressure.
        mat[0] = 32'h000FF; mat[1] = 32'h00100; mat[2] = 32'hFFFFF; mat[3] = 32'h0007F;
        check("sat_row0_model", 64'(exp_row(0)), 64'h7FFFFFFF);
        run_txn(32'h200, 1, 1'b0, -1);

        // Backpressure on row 1.
        for (int e = 0; e < int'(N * N); e++) mat[e] = e;
        run_txn(32'h100, 2, 1'b0, -1);

        // Ignored last/valid events.
        run_txn(32'h100, 0, 1'b1, -1);

        // Address wrap.
        run_txn(32'hFFFFFFF8, 0, 1'b0, -1);

        // Reset while row 2 is presented, then a clean full run.
        run_txn(32'h100, 0, 1'b0, 2);
        run_txn(32'h100, 0, 1'b0, -1);

        // Random matrices, bases and backpressure.
        for (int t = 0; t < 8; t++) begin
            for (int e = 0; e < int'(N * N); e++) begin
                mat[e] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 255)
                                                     : $urandom_range(0, 20'hFFFFF);
            end
            run_txn($urandom, 1, 1'(t % 2), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
